// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state codes,
// hazard cause codes and the default MUL/DIV timeout.
package hazard_ctrl_pkg;

    localparam logic [1:0] S_RUN        = 2'd0;
    localparam logic [1:0] S_LOAD_GUARD = 2'd1;
    localparam logic [1:0] S_MULDIV     = 2'd2;
    localparam logic [1:0] S_MEM_WAIT   = 2'd3;

    typedef enum logic [1:0] {
        CAUSE_LOAD = 2'd0,
        CAUSE_BR   = 2'd1,
        CAUSE_MD   = 2'd2,
        CAUSE_MEM  = 2'd3
    } cause_e;

    localparam int MULDIV_MAX_CYC_DEFAULT = 34;

endpackage

// File: rtl/stall_perf_counter.sv
// Wrapping stall-cycle counter for one hazard cause; only built when
// STALL_PERF_CNT_EN is defined.
`ifdef STALL_PERF_CNT_EN
module stall_perf_counter #(
    parameter int PERF_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              clear,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, branch,
// MUL/DIV and data-memory hazards. Per-cause counters under STALL_PERF_CNT_EN.
module pipeline_stall_controller
    import hazard_ctrl_pkg::*;
#(
    parameter int MULDIV_MAX_CYC = MULDIV_MAX_CYC_DEFAULT,
    parameter int CNT_W          = 6,
    parameter int PERF_W         = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              LOAD_BUBBLE,
    input  logic              BRANCH_TAKEN,
    input  logic              MULDIV_START,
    input  logic              MULDIV_DONE,
    input  logic              DMEM_BUSY,
    output logic              PC_STALL,
    output logic              IF_ID_STALL,
    output logic              ID_EX_STALL,
    output logic              EX_MEM_STALL,
    output logic              IF_ID_FLUSH,
    output logic              ID_EX_FLUSH,
    output logic              EX_MEM_FLUSH,
    output logic              MULDIV_TIMEOUT,
    output logic [PERF_W-1:0] PERF_LOAD,
    output logic [PERF_W-1:0] PERF_BR,
    output logic [PERF_W-1:0] PERF_MD,
    output logic [PERF_W-1:0] PERF_MEM
);

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             timeout_reg, timeout_next;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        timeout_next = timeout_reg;
        PC_STALL     = 1'b0;
        IF_ID_STALL  = 1'b0;
        ID_EX_STALL  = 1'b0;
        EX_MEM_STALL = 1'b0;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_FLUSH  = 1'b0;
        EX_MEM_FLUSH = 1'b0;

        case (state_reg)
            S_RUN, S_LOAD_GUARD: begin
                state_next = S_RUN;
                if (DMEM_BUSY) begin
                    PC_STALL     = 1'b1;
                    IF_ID_STALL  = 1'b1;
                    ID_EX_STALL  = 1'b1;
                    EX_MEM_STALL = 1'b1;
                    state_next   = S_MEM_WAIT;
                end else if (BRANCH_TAKEN) begin
                    IF_ID_FLUSH = 1'b1;
                    ID_EX_FLUSH = 1'b1;
                end else if (MULDIV_START) begin
                    // A same-cycle DONE is a single-cycle op: nothing to hold.
                    if (!MULDIV_DONE) begin
                        PC_STALL     = 1'b1;
                        IF_ID_STALL  = 1'b1;
                        ID_EX_STALL  = 1'b1;
                        EX_MEM_FLUSH = 1'b1;
                        cnt_next     = CNT_W'(1);
                        state_next   = S_MULDIV;
                    end
                end else if (LOAD_BUBBLE && state_reg == S_RUN) begin
                    // In the guard cycle the held instruction already has its forward.
                    PC_STALL    = 1'b1;
                    IF_ID_STALL = 1'b1;
                    ID_EX_FLUSH = 1'b1;
                    state_next  = S_LOAD_GUARD;
                end
            end
            S_MULDIV: begin
                if (MULDIV_DONE || cnt_reg == CNT_W'(MULDIV_MAX_CYC)) begin
                    state_next = S_RUN;
                    if (!MULDIV_DONE) begin
                        timeout_next = 1'b1;
                    end
                end else begin
                    PC_STALL    = 1'b1;
                    IF_ID_STALL = 1'b1;
                    ID_EX_STALL = 1'b1;
                    // Memory wait holds the older op in MEM instead of bubbling it.
                    if (DMEM_BUSY) begin
                        EX_MEM_STALL = 1'b1;
                    end else begin
                        EX_MEM_FLUSH = 1'b1;
                    end
                    if (cnt_reg != '1) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            S_MEM_WAIT: begin
                if (DMEM_BUSY) begin
                    PC_STALL     = 1'b1;
                    IF_ID_STALL  = 1'b1;
                    ID_EX_STALL  = 1'b1;
                    EX_MEM_STALL = 1'b1;
                end else begin
                    state_next = S_RUN;
                end
            end
            default: state_next = S_RUN;
        endcase

        if (RESET) begin
            PC_STALL     = 1'b0;
            IF_ID_STALL  = 1'b0;
            ID_EX_STALL  = 1'b0;
            EX_MEM_STALL = 1'b0;
            IF_ID_FLUSH  = 1'b0;
            ID_EX_FLUSH  = 1'b0;
            EX_MEM_FLUSH = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg   <= S_RUN;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign MULDIV_TIMEOUT = timeout_reg;

`ifdef STALL_PERF_CNT_EN
    logic [3:0]        perf_inc;
    logic [PERF_W-1:0] perf_cnt [4];

    // Cause is recovered from the control pattern: only a branch flushes IF/ID,
    // only a load flushes ID/EX alone, and memory is the only non-MUL/DIV EX/MEM stall.
    assign perf_inc[CAUSE_LOAD] = ID_EX_FLUSH && !IF_ID_FLUSH;
    assign perf_inc[CAUSE_BR]   = IF_ID_FLUSH;
    assign perf_inc[CAUSE_MD]   = EX_MEM_FLUSH || (state_reg == S_MULDIV && PC_STALL);
    assign perf_inc[CAUSE_MEM]  = EX_MEM_STALL && state_reg != S_MULDIV;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_perf
            stall_perf_counter #(.PERF_W(PERF_W)) u_cnt (
                .CLK   (CLK),
                .RESET (RESET),
                .clear (1'b0),
                .inc   (perf_inc[gi]),
                .count (perf_cnt[gi])
            );
        end
    endgenerate

    assign PERF_LOAD = perf_cnt[CAUSE_LOAD];
    assign PERF_BR   = perf_cnt[CAUSE_BR];
    assign PERF_MD   = perf_cnt[CAUSE_MD];
    assign PERF_MEM  = perf_cnt[CAUSE_MEM];
`else
    assign PERF_LOAD = '0;
    assign PERF_BR   = '0;
    assign PERF_MD   = '0;
    assign PERF_MEM  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: directed hazard scenarios
// with literal expectations, then randomized traffic against a behavioural model.
module tb_pipeline_stall_controller;

    logic        CLK = 1'b0;
    logic        RESET, LOAD_BUBBLE, BRANCH_TAKEN, MULDIV_START, MULDIV_DONE, DMEM_BUSY;
    logic        PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL;
    logic        IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MULDIV_TIMEOUT;
    logic [31:0] PERF_LOAD, PERF_BR, PERF_MD, PERF_MEM;

    pipeline_stall_controller dut (
        .CLK(CLK), .RESET(RESET), .LOAD_BUBBLE(LOAD_BUBBLE), .BRANCH_TAKEN(BRANCH_TAKEN),
        .MULDIV_START(MULDIV_START), .MULDIV_DONE(MULDIV_DONE), .DMEM_BUSY(DMEM_BUSY),
        .PC_STALL(PC_STALL), .IF_ID_STALL(IF_ID_STALL), .ID_EX_STALL(ID_EX_STALL),
        .EX_MEM_STALL(EX_MEM_STALL), .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH),
        .EX_MEM_FLUSH(EX_MEM_FLUSH), .MULDIV_TIMEOUT(MULDIV_TIMEOUT),
        .PERF_LOAD(PERF_LOAD), .PERF_BR(PERF_BR), .PERF_MD(PERF_MD), .PERF_MEM(PERF_MEM)
    );

    always #5 CLK = ~CLK;

    // {PC, IF/ID, ID/EX, EX/MEM stall, IF/ID, ID/EX, EX/MEM flush}
    localparam logic [6:0] O_NONE  = 7'b0000_000;
    localparam logic [6:0] O_LOAD  = 7'b1100_010;
    localparam logic [6:0] O_BR    = 7'b0000_110;
    localparam logic [6:0] O_MD    = 7'b1110_001;
    localparam logic [6:0] O_FREEZE = 7'b1111_000;
    localparam int         MD_MAX  = 34;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model: what the pipeline is currently waiting on, in plain terms.
    bit          m_guard;     // previous cycle issued a load bubble
    bit          m_mem;       // frozen waiting for data memory
    bit          m_md;        // MUL/DIV in flight
    int          m_elapsed;   // cycles since the MUL/DIV started
    bit          m_timeout;
    int unsigned m_perf [4];  // load, branch, muldiv, mem

    logic [6:0] outs;
    assign outs = {PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL,
                   IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_eval(output logic [6:0] o, output bit ng, output bit nm, output bit nd,
                              output int ne, output bit nt, output bit [3:0] inc);
        o = O_NONE; ng = 1'b0; nm = m_mem; nd = m_md; ne = m_elapsed; nt = m_timeout; inc = '0;
        if (RESET) begin
            nm = 1'b0; nd = 1'b0; ne = 0; nt = 1'b0;
        end else if (m_mem) begin
            if (DMEM_BUSY) begin o = O_FREEZE; inc[3] = 1'b1; end
            else nm = 1'b0;
        end else if (m_md) begin
            if (MULDIV_DONE || m_elapsed >= MD_MAX) begin
                nd = 1'b0;
                if (!MULDIV_DONE) nt = 1'b1;
            end else begin
                o = DMEM_BUSY ? O_FREEZE : O_MD;
                ne = m_elapsed + 1;
                inc[2] = 1'b1;
            end
        end else if (DMEM_BUSY) begin
            o = O_FREEZE; nm = 1'b1; inc[3] = 1'b1;
        end else if (BRANCH_TAKEN) begin
            o = O_BR; inc[1] = 1'b1;
        end else if (MULDIV_START) begin
            if (!MULDIV_DONE) begin o = O_MD; nd = 1'b1; ne = 1; inc[2] = 1'b1; end
        end else if (LOAD_BUBBLE && !m_guard) begin
            o = O_LOAD; ng = 1'b1; inc[0] = 1'b1;
        end
    endtask

    always @(posedge CLK) begin
        logic [6:0] o; bit ng, nm, nd, nt; int ne; bit [3:0] inc;
        model_eval(o, ng, nm, nd, ne, nt, inc);
        m_guard = ng; m_mem = nm; m_md = nd; m_elapsed = ne; m_timeout = nt;
        for (int i = 0; i < 4; i++) m_perf[i] = RESET ? 0 : m_perf[i] + inc[i];
    end

    always @(negedge CLK) begin
        logic [6:0] o; bit ng, nm, nd, nt; int ne; bit [3:0] inc;
        if (check_en) begin
            model_eval(o, ng, nm, nd, ne, nt, inc);
            chk("ctrl", 32'(outs), 32'(o));
            chk("timeout", 32'(MULDIV_TIMEOUT), 32'(m_timeout));
            chk("excl", 32'({PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL} &
                            {1'b0, IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH}), 32'd0);
`ifdef STALL_PERF_CNT_EN
            chk("perf_load", PERF_LOAD, m_perf[0]);
            chk("perf_br",   PERF_BR,   m_perf[1]);
            chk("perf_md",   PERF_MD,   m_perf[2]);
            chk("perf_mem",  PERF_MEM,  m_perf[3]);
`else
            chk("perf_tied", PERF_LOAD | PERF_BR | PERF_MD | PERF_MEM, 32'd0);
`endif
        end
    end

    task automatic drive(input bit r, input bit l, input bit b, input bit s, input bit d, input bit m);
        RESET = r; LOAD_BUBBLE = l; BRANCH_TAKEN = b; MULDIV_START = s; MULDIV_DONE = d; DMEM_BUSY = m;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cyc_expect(input string name, input logic [6:0] exp);
        @(negedge CLK);
        chk(name, 32'(outs), 32'(exp));
        $display("cycle %s outs=%b timeout=%b", name, outs, MULDIV_TIMEOUT);
        tick();
    endtask

    initial begin
        m_guard = 0; m_mem = 0; m_md = 0; m_elapsed = 0; m_timeout = 0;
        for (int i = 0; i < 4; i++) m_perf[i] = 0;
        drive(1, 1, 0, 1, 0, 1);
        tick();
        check_en = 1'b1;
        cyc_expect("reset_out", O_NONE);
        chk("reset_timeout", 32'(MULDIV_TIMEOUT), 32'd0);
        chk("reset_perf", PERF_LOAD | PERF_BR | PERF_MD | PERF_MEM, 32'd0);

        // 1: load-use bubble then guard cycle
        drive(0, 1, 0, 0, 0, 0);
        cyc_expect("t1_load", O_LOAD);
        cyc_expect("t1_guard", O_NONE);
        drive(0, 0, 0, 0, 0, 0);
        cyc_expect("t1_idle", O_NONE);

        // 2: branch overrides load
        drive(0, 1, 1, 0, 0, 0);
        cyc_expect("t2_branch", O_BR);
        drive(0, 0, 0, 0, 0, 0);
        cyc_expect("t2_after", O_NONE);

        // 3: MUL/DIV done 33 cycles after start
        drive(0, 0, 0, 1, 0, 0);
        cyc_expect("t3_start", O_MD);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 33; i++) cyc_expect("t3_busy", O_MD);
        drive(0, 0, 0, 0, 1, 0);
        cyc_expect("t3_done", O_NONE);
        drive(0, 0, 0, 0, 0, 0);
        chk("t3_timeout", 32'(MULDIV_TIMEOUT), 32'd0);

        // 4: MUL/DIV never finishes
        drive(0, 0, 0, 1, 0, 0);
        cyc_expect("t4_start", O_MD);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 1; i < MD_MAX; i++) cyc_expect("t4_busy", O_MD);
        cyc_expect("t4_release", O_NONE);
        chk("t4_timeout", 32'(MULDIV_TIMEOUT), 32'd1);

        // 5: memory wait inside MUL/DIV, then from S_RUN
        drive(0, 0, 0, 1, 0, 0);
        cyc_expect("t5_start", O_MD);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc_expect("t5_md", O_MD);
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc_expect("t5_md_mem", O_FREEZE);
        drive(0, 0, 0, 0, 0, 0);
        cyc_expect("t5_md2", O_MD);
        drive(0, 0, 0, 0, 1, 0);
        cyc_expect("t5_done", O_NONE);
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc_expect("t5_mem", O_FREEZE);
        drive(0, 0, 0, 0, 0, 0);
        cyc_expect("t5_mem_exit", O_NONE);
        cyc_expect("t5_idle", O_NONE);
        chk("t5_timeout_sticky", 32'(MULDIV_TIMEOUT), 32'd1);
`ifdef STALL_PERF_CNT_EN
        chk("t5_perf_load", PERF_LOAD, 32'd1);
        chk("t5_perf_br",   PERF_BR,   32'd1);
        chk("t5_perf_md",   PERF_MD,   32'd77);
        chk("t5_perf_mem",  PERF_MEM,  32'd5);
`endif

        // 6: reset in the middle of a MUL/DIV
        drive(0, 0, 0, 1, 0, 0);
        cyc_expect("t6_start", O_MD);
        drive(0, 0, 0, 0, 0, 0);
        cyc_expect("t6_md", O_MD);
        drive(1, 0, 0, 0, 0, 0);
        cyc_expect("t6_reset", O_NONE);
        drive(0, 1, 0, 0, 0, 0);
        @(negedge CLK);
        chk("t6_timeout", 32'(MULDIV_TIMEOUT), 32'd0);
        chk("t6_perf", PERF_LOAD | PERF_BR | PERF_MD | PERF_MEM, 32'd0);
        chk("t6_run_load", 32'(outs), 32'(O_LOAD));
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();

        // Randomized traffic, checked every cycle by the model
        for (int n = 0; n < 4000; n++) begin
            drive($urandom_range(299) == 0, $urandom_range(2) == 0, $urandom_range(5) == 0,
                  $urandom_range(5) == 0, $urandom_range(39) == 0, $urandom_range(5) == 0);
            tick();
            if (n % 500 == 0)
                $display("random cycle %0d outs=%b timeout=%b", n, outs, MULDIV_TIMEOUT);
        end

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
